reg_scoreboard: RTL and testbench

//  Read-side companion of the register file: tracks which architectural registers have a

---
 rtl/reg_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks registers with a pending multi-cycle write and
// stalls issue on RAW/WAW hazards or when the in-flight tracker is full.

module sb_busy_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic busy_q
);
    // set and clr never target the same register in one cycle (waw blocks it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     busy_q <= 1'b0;
        else if (flush) busy_q <= 1'b0;
        else if (set)   busy_q <= 1'b1;
        else if (clr)   busy_q <= 1'b0;
    end
endmodule

module reg_scoreboard #(
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int MAX_OUT = 4,
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [AW-1:0]    iss_rs1,
    input  logic [AW-1:0]    iss_rs2,
    input  logic             iss_use_rs2,
    input  logic [AW-1:0]    iss_rd,
    input  logic             iss_we,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic [NREGS-1:0] busy_vec,
    output logic [CW-1:0]    outstanding,
    output logic             hazard,
    output logic             wb_err
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wb_err_q, wb_err_d;
    logic             raw1, raw2, waw, full;
    logic             acc_set, wb_clr;

    assign raw1 = busy[iss_rs1] && (iss_rs1 != '0);
    assign raw2 = iss_use_rs2 && busy[iss_rs2] && (iss_rs2 != '0);
    assign waw  = iss_we && (iss_rd != '0) && busy[iss_rd];
    assign full = (cnt_q == CW'(MAX_OUT)) && iss_we && (iss_rd != '0);

    assign hazard    = raw1 | raw2 | waw | full;
    assign iss_ready = !hazard && !flush;

    // Only tracked writes (we && rd!=0) touch state; others pass straight through.
    assign acc_set = iss_valid && iss_ready && iss_we && (iss_rd != '0);
    assign wb_clr  = wb_valid && busy[wb_rd];

    assign busy[0]    = 1'b0;
    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cell
        assign set_vec[i] = acc_set && (iss_rd == AW'(i));
        assign clr_vec[i] = wb_clr  && (wb_rd  == AW'(i));

        sb_busy_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .set    (set_vec[i]),
            .clr    (clr_vec[i]),
            .busy_q (busy[i])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (acc_set && !wb_clr)
            cnt_d = cnt_q + CW'(1);
        else if (!acc_set && wb_clr)
            cnt_d = cnt_q - CW'(1);
    end

    // A flush squashes the writeback too, so it cannot raise the error flag.
    always_comb begin
        wb_err_d = wb_err_q;
        if (!flush && wb_valid && !busy[wb_rd])
            wb_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec    = busy;
    assign outstanding = cnt_q;
    assign wb_err      = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW stall/release, capacity,
// back-to-back issue+writeback, wb error flag, flush and async reset.

module tb_reg_scoreboard;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             iss_valid;
    logic             iss_ready;
    logic [AW-1:0]    iss_rs1, iss_rs2, iss_rd;
    logic             iss_use_rs2;
    logic             iss_we;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [NREGS-1:0] busy_vec;
    logic [CW-1:0]    outstanding;
    logic             hazard;
    logic             wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_scoreboard #(.NREGS(NREGS), .AW(AW), .MAX_OUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_use_rs2 (iss_use_rs2),
        .iss_rd      (iss_rd),
        .iss_we      (iss_we),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy_vec    (busy_vec),
        .outstanding (outstanding),
        .hazard      (hazard),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_use_rs2 = 0;
        iss_rd = 0; iss_we = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic issue_wr(input logic [AW-1:0] rd);
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = rd;
        tick();
        idle();
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle();
        repeat (2) tick();
        #1;
        n_checks++; if (busy_vec !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", outstanding); end
        n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wberr: got %b want 0", wb_err); end
        rst_n = 1;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", iss_ready); end
    endtask

    task automatic test_issue;
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = 5;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: got %b want 1", iss_ready); end
        tick();
        idle();
        n_checks++; if (busy_vec !== 32'h0000_0020) begin n_fail++; $display("FAIL issue_busy: got %h want 00000020", busy_vec); end
        n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL issue_outst: got %0d want 1", outstanding); end
    endtask

    task automatic test_raw;
        idle();
        iss_valid = 1; iss_rs1 = 5;
        #1;
        n_checks++; if (iss_ready !== 1'b0 || hazard !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got ready=%b hazard=%b want 0/1", iss_ready, hazard); end
        tick();
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_hold: got %b want 0", iss_ready); end
        wb_valid = 1; wb_rd = 5;
        #1;
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_nobypass: got %b want 0", iss_ready); end
        tick();
        wb_valid = 0; wb_rd = 0;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", iss_ready); end
        n_checks++; if (busy_vec !== '0 || outstanding !== 3'd0) begin n_fail++; $display("FAIL raw_cleared: got busy=%h outst=%0d want 0/0", busy_vec, outstanding); end
        tick();
        idle();
    endtask

    task automatic test_full;
        for (int r = 1; r <= 4; r++) issue_wr(AW'(r));
        n_checks++; if (outstanding !== 3'd4 || busy_vec !== 32'h0000_001E) begin n_fail++; $display("FAIL full_fill: got busy=%h outst=%0d want 0000001e/4", busy_vec, outstanding); end
        iss_valid = 1; iss_we = 1; iss_rd = 6;
        #1;
        n_checks++; if (iss_ready !== 1'b0 || hazard !== 1'b1) begin n_fail++; $display("FAIL full_stall: got ready=%b hazard=%b want 0/1", iss_ready, hazard); end
        tick();
        n_checks++; if (outstanding !== 3'd4 || busy_vec[6] !== 1'b0) begin n_fail++; $display("FAIL full_nochange: got outst=%0d busy6=%b want 4/0", outstanding, busy_vec[6]); end
        idle();
        iss_valid = 1; iss_rs1 = 7;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL full_nonwrite: got %b want 1", iss_ready); end
        tick();
        n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_nonwrite_cnt: got %0d want 4", outstanding); end
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = 0;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL full_rd0: got %b want 1", iss_ready); end
        idle();
        iss_valid = 1; iss_rs2 = 3; iss_use_rs2 = 0;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL rs2_unused: got %b want 1", iss_ready); end
        iss_use_rs2 = 1;
        #1;
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL rs2_raw: got %b want 0", iss_ready); end
        idle();
        tick();
    endtask

    task automatic test_back_to_back;
        idle();
        wb_valid = 1; wb_rd = 4;
        tick();
        idle();
        n_checks++; if (outstanding !== 3'd3 || busy_vec !== 32'h0000_000E) begin n_fail++; $display("FAIL b2b_pre: got busy=%h outst=%0d want 0000000e/3", busy_vec, outstanding); end
        iss_valid = 1; iss_we = 1; iss_rd = 8; wb_valid = 1; wb_rd = 1;
        #1;
        n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", iss_ready); end
        tick();
        idle();
        n_checks++; if (busy_vec !== 32'h0000_010C || outstanding !== 3'd3) begin n_fail++; $display("FAIL b2b_state: got busy=%h outst=%0d want 0000010c/3", busy_vec, outstanding); end
    endtask

    task automatic test_wb_err;
        idle();
        n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL wberr_pre: got %b want 0", wb_err); end
        wb_valid = 1; wb_rd = 9;
        tick();
        idle();
        n_checks++; if (wb_err !== 1'b1 || outstanding !== 3'd3 || busy_vec !== 32'h0000_010C) begin n_fail++; $display("FAIL wberr_set: got err=%b outst=%0d busy=%h want 1/3/0000010c", wb_err, outstanding, busy_vec); end
        repeat (3) tick();
        n_checks++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wberr_sticky: got %b want 1", wb_err); end
        iss_valid = 1; iss_we = 1; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0; iss_use_rs2 = 1;
        #1;
        n_checks++; if (iss_ready !== 1'b1 || hazard !== 1'b0) begin n_fail++; $display("FAIL x0_nostall: got ready=%b hazard=%b want 1/0", iss_ready, hazard); end
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = 2;
        #1;
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", iss_ready); end
        idle();
    endtask

    task automatic test_flush;
        idle();
        iss_valid = 1; iss_we = 1; iss_rd = 10; flush = 1;
        #1;
        n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", iss_ready); end
        tick();
        idle();
        n_checks++; if (busy_vec !== '0 || outstanding !== 3'd0) begin n_fail++; $display("FAIL flush_clear: got busy=%h outst=%0d want 0/0", busy_vec, outstanding); end
        n_checks++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL flush_wberr: got %b want 1", wb_err); end
        issue_wr(5);
        issue_wr(6);
        n_checks++; if (outstanding !== 3'd2 || busy_vec !== 32'h0000_0060) begin n_fail++; $display("FAIL refill: got busy=%h outst=%0d want 00000060/2", busy_vec, outstanding); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (busy_vec !== '0 || outstanding !== 3'd0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL async_rst: got busy=%h outst=%0d err=%b want 0/0/0", busy_vec, outstanding, wb_err); end
        tick();
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_issue();
        test_raw();
        test_full();
        test_back_to_back();
        test_wb_err();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
